fetch_unit: RTL

Instruction-fetch stage of the RISC-V core, directly upstream of the combinational instruction memory. Holds the program counter and drives the fetch address. Captures the returned instruction word, together with its PC, into the IF/ID register and hands it to decode through a valid/ready handshake. Handles control-flow redirects with a flush, stalls under decode backpressure, and optionally halts on an all-zero instruction word.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Holds the PC, drives a combinational instruction memory, and hands fetched
// words to decode over a valid/ready handshake with redirect flush and stall.
// Optional feature macro: FETCH_HALT_ON_ZERO_EN (halt fetch on an all-zero word).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] fetch_count,
  output logic        halted
);

  localparam int unsigned XLEN       = 32;
  localparam logic [XLEN-1:0] NOP_INSN   = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

  logic [XLEN-1:0] r_pc;
  logic            r_id_valid;
  logic [XLEN-1:0] r_id_instr;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] r_id_pc_plus4;
  logic [XLEN-1:0] r_fetch_count;

  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_fire;
  logic            w_load;
  logic            w_unused_tgt_lsb;

  assign w_redirect_pc    = {redirect_target[XLEN-1:2], 2'b00};
  assign w_pc_plus4       = r_pc + INSN_BYTES;
  assign w_unused_tgt_lsb = ^redirect_target[1:0];

`ifdef FETCH_HALT_ON_ZERO_EN
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_zero_word;

  assign w_zero_word = (imem_instr == '0);
  assign w_fire      = (r_state == ST_RUN) && (!r_id_valid || id_ready);
  assign w_load      = w_fire && !w_zero_word;
  assign halted      = (r_state == ST_HALT);

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next state: a zero word stops fetch; only a redirect restarts it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (!redirect_valid && w_fire && w_zero_word) w_state_nxt = ST_HALT;
      ST_HALT: if (redirect_valid) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end
`else
  assign w_fire = !r_id_valid || id_ready;
  assign w_load = w_fire;
  assign halted = 1'b0;
`endif

  // PC, IF/ID register and fetch counter; redirect beats fire beats hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_instr    <= NOP_INSN;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= INSN_BYTES;
      r_fetch_count <= '0;
    end else if (redirect_valid) begin
      r_pc       <= w_redirect_pc;
      r_id_valid <= 1'b0;
    end else if (w_load) begin
      r_id_instr    <= imem_instr;
      r_id_pc       <= r_pc;
      r_id_pc_plus4 <= w_pc_plus4;
      r_id_valid    <= 1'b1;
      r_pc          <= w_pc_plus4;
      r_fetch_count <= r_fetch_count + XLEN'(1);
    end else if (w_fire) begin
      // Halting fire: the zero word is dropped and the slot empties.
      r_id_valid <= 1'b0;
    end
  end

  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign fetch_count = r_fetch_count;

endmodule
